countdown_timer: RTL

// - Programmable down-counter: counts from a loaded value to zero and flags the terminal count.
// - Complements the up-counter with overflow: load-then-count-down instead of count-up-then-wrap.
// - Used as a timeout/interval timer by control FSMs.
// - Value handoff uses a valid/ready load port.
// - done is a registered single-cycle pulse.

---
 rtl/countdown_timer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Programmable down-counter with a valid/ready load port. It
//               counts from the loaded value to zero and emits a registered
//               one-cycle done pulse at the terminal count. An abort input
//               cancels a running count without producing a done pulse.
//               Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN
//               (periodic mode: reload from the last accepted load value at
//               the terminal count and accept loads while running).
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_running;
  logic             w_terminal;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;

  // Periodic mode can take a new value at any time, including mid-run.
  assign load_ready = 1'b1;
`else
  // One-shot mode only accepts a new value once the previous count is over.
  assign load_ready = (r_state == S_IDLE);
`endif

  assign w_running  = (r_state == S_RUN);
  assign w_load     = load_valid && load_ready;
  // A count of 0 never exists in RUN, but treating it as terminal keeps the
  // counter from ever wrapping to all-ones.
  assign w_terminal = (r_count <= C_ONE);

  // Next-state, next-count and done decode; abort > load > decrement.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    if (w_running && abort) begin
      // Cancel: no done pulse; the reload value (if any) is kept.
      w_state_nxt = S_IDLE;
      w_count_nxt = C_ZERO;
    end else if (w_load) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      w_reload_nxt = load_value;
`endif
      if (load_value != C_ZERO) begin
        w_state_nxt = S_RUN;
        w_count_nxt = load_value;
      end else begin
        // A zero-length interval finishes immediately without entering RUN.
        w_state_nxt = S_IDLE;
        w_count_nxt = C_ZERO;
        w_done_nxt  = 1'b1;
      end
    end else if (w_running && enable) begin
      if (w_terminal) begin
        w_done_nxt = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        w_count_nxt = r_reload;
`else
        w_state_nxt = S_IDLE;
        w_count_nxt = C_ZERO;
`endif
      end else begin
        w_count_nxt = r_count - C_ONE;
      end
    end
  end

  // State, count and done registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= C_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  // Reload register holds the most recently accepted load value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= C_ZERO;
    end else begin
      r_reload <= w_reload_nxt;
    end
  end
`endif

  assign count = r_count;
  assign busy  = w_running;
  assign done  = r_done;

endmodule
`default_nettype wire
